// File: rtl/pipe_irq_ctrl.sv
// Interrupt sequencer for the 5-stage MIPS pipeline: takes external interrupts
// at safe points, saves EPC, redirects fetch, and enforces a post-ERET holdoff.
module pipe_irq_ctrl #(
  parameter logic [31:0] HANDLER_ADDR = 32'h0000_0080,
  parameter int          HOLDOFF      = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        irq,
  input  logic        ie,
  input  logic        valid_id,
  input  logic [31:0] pc_id,
  input  logic        stall_id,
  input  logic        branch_ex,
  input  logic        eret_id,
  output logic        flush_ifid,
  output logic        flush_idex,
  output logic        pc_redirect,
  output logic [31:0] pc_target,
  output logic        irq_ack,
  output logic [31:0] epc,
  output logic        in_handler
);

  typedef enum logic [1:0] {
    IDLE,
    HANDLER,
    HOLD
  } stateT;

  stateT      state;
  stateT      nextState;
  logic [3:0] holdCount;
  logic [3:0] nextHoldCount;
  logic       take;
  logic       ret;

  // A take never splits a branch from its delay slot and never squashes a stalled ID.
  assign take = ~reset & (state == IDLE) & irq & ie & valid_id & ~stall_id & ~branch_ex;
  assign ret  = ~reset & (state == HANDLER) & eret_id & valid_id & ~stall_id;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      holdCount <= 4'd0;
    end else begin
      state     <= nextState;
      holdCount <= nextHoldCount;
    end
  end

  always_comb begin
    nextState     = state;
    nextHoldCount = holdCount;
    flush_ifid    = 1'b0;
    flush_idex    = 1'b0;
    pc_redirect   = 1'b0;
    pc_target     = 32'd0;
    irq_ack       = 1'b0;
    unique case (state)
      IDLE: begin
        if (take) begin
          irq_ack     = 1'b1;
          flush_ifid  = 1'b1;
          flush_idex  = 1'b1;
          pc_redirect = 1'b1;
          pc_target   = HANDLER_ADDR;
          nextState   = HANDLER;
        end
      end
      HANDLER: begin
        // The ERET itself is left in ID/EX to drain as a no-op.
        if (ret) begin
          flush_ifid    = 1'b1;
          pc_redirect   = 1'b1;
          pc_target     = epc;
          nextHoldCount = 4'(HOLDOFF - 1);
          nextState     = HOLD;
        end
      end
      HOLD: begin
        if (holdCount == 4'd0) begin
          nextState = IDLE;
        end else begin
          nextHoldCount = holdCount - 4'd1;
        end
      end
      default: begin
        nextState = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      epc        <= 32'd0;
      in_handler <= 1'b0;
    end else if (take) begin
      epc        <= pc_id;
      in_handler <= 1'b1;
    end else if (ret) begin
      in_handler <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pipe_irq_ctrl.sv
// Self-checking bench for pipe_irq_ctrl: directed scenarios followed by random
// traffic, all checked against a mode/holdoff reference model.
module tb_pipe_irq_ctrl;

  localparam logic [31:0] HANDLER_ADDR = 32'h0000_0080;
  localparam int          HOLDOFF      = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        irq, ie, valid_id, stall_id, branch_ex, eret_id;
  logic [31:0] pc_id;
  logic        flush_ifid, flush_idex, pc_redirect, irq_ack, in_handler;
  logic [31:0] pc_target, epc;

  int checks   = 0;
  int failures = 0;

  // Reference model: handler mode flag, saved PC, and cycles of holdoff left.
  bit          mInHandler;
  logic [31:0] mEpc;
  int          mHoldLeft;

  pipe_irq_ctrl #(.HANDLER_ADDR(HANDLER_ADDR), .HOLDOFF(HOLDOFF)) dut (
    .clk(clk), .reset(reset), .irq(irq), .ie(ie), .valid_id(valid_id),
    .pc_id(pc_id), .stall_id(stall_id), .branch_ex(branch_ex), .eret_id(eret_id),
    .flush_ifid(flush_ifid), .flush_idex(flush_idex), .pc_redirect(pc_redirect),
    .pc_target(pc_target), .irq_ack(irq_ack), .epc(epc), .in_handler(in_handler)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic modelReset();
    mInHandler = 1'b0;
    mEpc       = 32'd0;
    mHoldLeft  = 0;
  endtask

  // One clock: check combinational responses mid-cycle, then registered state after the edge.
  task automatic runCycle(input string tag);
    bit mTake, mRet;
    @(negedge clk);
    mTake = !mInHandler && (mHoldLeft == 0) && irq && ie && valid_id && !stall_id && !branch_ex;
    mRet  = mInHandler && eret_id && valid_id && !stall_id;
    checkOutput({tag, ".irq_ack"},     {31'd0, irq_ack},     {31'd0, mTake});
    checkOutput({tag, ".flush_ifid"},  {31'd0, flush_ifid},  {31'd0, mTake | mRet});
    checkOutput({tag, ".flush_idex"},  {31'd0, flush_idex},  {31'd0, mTake});
    checkOutput({tag, ".pc_redirect"}, {31'd0, pc_redirect}, {31'd0, mTake | mRet});
    checkOutput({tag, ".pc_target"},   pc_target,
                mTake ? HANDLER_ADDR : (mRet ? mEpc : 32'd0));
    @(posedge clk);
    #1;
    if (mTake) begin
      mInHandler = 1'b1;
      mEpc       = pc_id;
    end else if (mRet) begin
      mInHandler = 1'b0;
      mHoldLeft  = HOLDOFF;
    end else if (mHoldLeft > 0) begin
      mHoldLeft--;
    end
    checkOutput({tag, ".epc"},        epc,                  mEpc);
    checkOutput({tag, ".in_handler"}, {31'd0, in_handler}, {31'd0, mInHandler});
  endtask

  task automatic applyStimulus(input string tag, input bit irqV, input bit ieV,
                               input bit validV, input bit stallV, input bit branchV,
                               input bit eretV, input logic [31:0] pcV);
    irq = irqV; ie = ieV; valid_id = validV; stall_id = stallV;
    branch_ex = branchV; eret_id = eretV; pc_id = pcV;
    runCycle(tag);
  endtask

  initial begin
    reset = 1'b1;
    irq = 0; ie = 0; valid_id = 0; stall_id = 0; branch_ex = 0; eret_id = 0;
    pc_id = 32'd0;
    modelReset();
    #2;
    checkOutput("reset.epc",         epc,                  32'd0);
    checkOutput("reset.in_handler",  {31'd0, in_handler},  32'd0);
    checkOutput("reset.pc_redirect", {31'd0, pc_redirect}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    $display("[TB] basic take");
    applyStimulus("idle", 0, 1, 1, 0, 0, 0, 32'h0040_0000);
    applyStimulus("take", 1, 1, 1, 0, 0, 0, 32'h0040_0010);
    checkOutput("take.epc_value", epc, 32'h0040_0010);

    $display("[TB] return plus holdoff");
    applyStimulus("handler", 0, 1, 1, 0, 0, 0, 32'h0000_0080);
    applyStimulus("ret",     0, 1, 1, 0, 0, 1, 32'h0000_0084);
    applyStimulus("hold1",   1, 1, 1, 0, 0, 0, 32'h0040_0010);
    applyStimulus("hold2",   1, 1, 1, 0, 0, 0, 32'h0040_0014);
    applyStimulus("retake",  1, 1, 1, 0, 0, 0, 32'h0040_0018);
    checkOutput("retake.in_handler", {31'd0, in_handler}, 32'd1);

    $display("[TB] priority and no nesting");
    for (int i = 0; i < 10; i++)
      applyStimulus("nonest", 1, 1, 1, 0, 0, 0, 32'h0000_0090 + 32'(4 * i));
    applyStimulus("retprio", 1, 1, 1, 0, 0, 1, 32'h0000_00c0);
    applyStimulus("hold1b",  0, 1, 1, 0, 0, 0, 32'h0040_0018);
    applyStimulus("hold2b",  0, 1, 1, 0, 0, 0, 32'h0040_001c);

    $display("[TB] deferral");
    applyStimulus("stall1", 1, 1, 1, 1, 0, 0, 32'h0040_0100);
    applyStimulus("stall2", 1, 1, 1, 1, 0, 0, 32'h0040_0100);
    applyStimulus("branch", 1, 1, 1, 0, 1, 0, 32'h0040_0104);
    applyStimulus("deftake", 1, 1, 1, 0, 0, 0, 32'h0040_0108);
    checkOutput("deftake.epc_value", epc, 32'h0040_0108);
    applyStimulus("ret2", 0, 1, 1, 0, 0, 1, 32'h0000_0088);
    applyStimulus("h1", 0, 1, 1, 0, 0, 0, 32'h0040_0108);
    applyStimulus("h2", 0, 1, 1, 0, 0, 0, 32'h0040_010c);

    $display("[TB] masking");
    for (int i = 0; i < 20; i++)
      applyStimulus("masked", 1, 0, 1, 0, 0, 0, 32'h0040_0200 + 32'(4 * i));
    applyStimulus("strayeret", 0, 1, 1, 0, 0, 1, 32'h0040_0300);
    applyStimulus("novalid",   1, 1, 0, 0, 0, 0, 32'h0040_0304);

    $display("[TB] async reset mid-handler");
    applyStimulus("take3", 1, 1, 1, 0, 0, 0, 32'h0040_0400);
    irq = 1; ie = 1; valid_id = 1; eret_id = 1; pc_id = 32'h0000_0080;
    reset = 1'b1;
    #1;
    modelReset();
    checkOutput("arst.in_handler",  {31'd0, in_handler},  32'd0);
    checkOutput("arst.epc",         epc,                  32'd0);
    checkOutput("arst.pc_redirect", {31'd0, pc_redirect}, 32'd0);
    checkOutput("arst.flush_ifid",  {31'd0, flush_ifid},  32'd0);
    checkOutput("arst.flush_idex",  {31'd0, flush_idex},  32'd0);
    checkOutput("arst.irq_ack",     {31'd0, irq_ack},     32'd0);
    checkOutput("arst.pc_target",   pc_target,            32'd0);
    irq = 0; eret_id = 0;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    applyStimulus("posttake", 1, 1, 1, 0, 0, 0, 32'h0040_0500);
    checkOutput("posttake.epc_value", epc, 32'h0040_0500);

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      applyStimulus("rand",
                    $urandom_range(0, 1) == 1,
                    $urandom_range(0, 4) != 0,
                    $urandom_range(0, 4) != 0,
                    $urandom_range(0, 3) == 0,
                    $urandom_range(0, 4) == 0,
                    $urandom_range(0, 2) == 0,
                    {$urandom_range(0, 32'h00ff_ffff), 2'b00} | 32'h0040_0000);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
